// File: rtl/catch_scorer.sv
// catch_scorer
//   Sits between the hook and the score/timer block. It latches the type of
//   the item the hook grabbed. It paces the reel-in with weight-dependent step
//   pulses. When the hook gets back home it issues exactly one single-cycle
//   award to the score adder.
//
// Ports:
//   clk                 in   system clock
//   resetn              in   asynchronous active-low reset
//   game_active         in   round running (same net as timer_enable)
//   grab_valid          in   one-cycle pulse, hook touched an item
//   grab_type [1:0]     in   item type, sampled with grab_valid
//   hook_home           in   one-cycle pulse, hook reached home
//   carrying            out  item on the hook
//   carried_type [1:0]  out  latched item type (holds when idle)
//   reel_step           out  one-cycle reel advance pulse
//   score_adder_enable  out  one-cycle award pulse
//   score_to_add [2:0]  out  award value, 0 when not awarding
//   items_caught [5:0]  out  saturating count of awarded items
module catch_scorer #(
  parameter logic [25:0] STEP_LIGHT  = 26'd12499999,
  parameter logic [25:0] STEP_HEAVY  = 26'd49999999,
  parameter logic [2:0]  VAL_SMALL   = 3'd2,
  parameter logic [2:0]  VAL_BIG     = 3'd5,
  parameter logic [2:0]  VAL_ROCK    = 3'd1,
  parameter logic [2:0]  VAL_DIAMOND = 3'd7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       game_active,
  input  logic       grab_valid,
  input  logic [1:0] grab_type,
  input  logic       hook_home,
  output logic       carrying,
  output logic [1:0] carried_type,
  output logic       reel_step,
  output logic       score_adder_enable,
  output logic [2:0] score_to_add,
  output logic [5:0] items_caught
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CARRY = 2'd1;
  localparam logic [1:0] AWARD = 2'd2;

  logic [1:0]  state;
  logic [25:0] step_cnt;
  logic [25:0] load_val;
  logic [2:0]  award_val;
  logic        accept_grab;
  logic        award;

  // Big gold and rock are heavy; small gold and diamond are light.
  always_comb begin
    load_val = STEP_LIGHT - 26'd1;
    if (grab_type == 2'd1 || grab_type == 2'd2) begin
      load_val = STEP_HEAVY - 26'd1;
    end
  end

  always_comb begin
    award_val = VAL_SMALL;
    case (carried_type)
      2'd0: award_val = VAL_SMALL;
      2'd1: award_val = VAL_BIG;
      2'd2: award_val = VAL_ROCK;
      2'd3: award_val = VAL_DIAMOND;
      default: award_val = VAL_SMALL;
    endcase
  end

  assign accept_grab = (state == IDLE) && grab_valid && game_active;
  // If the round ends during AWARD, the award is suppressed.
  assign award = (state == AWARD) && game_active;

  // Main FSM. A grab during CARRY is ignored, so the latched type stays put.
  // hook_home in IDLE is an empty hook coming back and does nothing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      carried_type <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_grab) begin
            state        <= CARRY;
            carried_type <= grab_type;
          end
        end
        CARRY: begin
          if (!game_active) begin
            state <= IDLE;
          end else if (hook_home) begin
            state <= AWARD;
          end
        end
        AWARD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Step counter. It is loaded with period-1 on the grab edge.
  // It only runs while the FSM stays in CARRY, and it is parked at 0 otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_cnt <= 26'd0;
    end else if (accept_grab) begin
      step_cnt <= load_val;
    end else if (state == CARRY && game_active && !hook_home) begin
      if (step_cnt == 26'd0) begin
        case (carried_type)
          2'd1, 2'd2: step_cnt <= STEP_HEAVY - 26'd1;
          default:    step_cnt <= STEP_LIGHT - 26'd1;
        endcase
      end else begin
        step_cnt <= step_cnt - 26'd1;
      end
    end else begin
      step_cnt <= 26'd0;
    end
  end

  // Registered outputs, all derived from the current state.
  // They therefore lag the state by one cycle.
  // This is why carrying stays high through the award cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      carrying           <= 1'b0;
      reel_step          <= 1'b0;
      score_adder_enable <= 1'b0;
      score_to_add       <= 3'd0;
      items_caught       <= 6'd0;
    end else begin
      carrying           <= (state != IDLE);
      reel_step          <= (state == CARRY) && (step_cnt == 26'd0);
      score_adder_enable <= award;
      score_to_add       <= award ? award_val : 3'd0;
      if (award && items_caught != 6'd63) begin
        items_caught <= items_caught + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_catch_scorer.sv
// tb_catch_scorer
//   Directed bench for catch_scorer with short reel periods (light 4, heavy 8).
//   Award expectations are queued when hook_home is driven. A monitor on the
//   falling edge pops and compares them whenever score_adder_enable is seen.
module tb_catch_scorer;

  logic       clk;
  logic       resetn;
  logic       game_active;
  logic       grab_valid;
  logic [1:0] grab_type;
  logic       hook_home;
  logic       carrying;
  logic [1:0] carried_type;
  logic       reel_step;
  logic       score_adder_enable;
  logic [2:0] score_to_add;
  logic [5:0] items_caught;

  typedef struct packed {
    logic [2:0] val;
    logic [5:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   exp_count   = 0;

  catch_scorer #(
    .STEP_LIGHT(26'd4),
    .STEP_HEAVY(26'd8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .game_active(game_active),
    .grab_valid(grab_valid),
    .grab_type(grab_type),
    .hook_home(hook_home),
    .carrying(carrying),
    .carried_type(carried_type),
    .reel_step(reel_step),
    .score_adder_enable(score_adder_enable),
    .score_to_add(score_to_add),
    .items_caught(items_caught)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the sampling edge.
  task automatic applyStimulus(input logic gv, input logic [1:0] gt,
                               input logic hh, input logic ga);
    grab_valid  = gv;
    grab_type   = gt;
    hook_home   = hh;
    game_active = ga;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] item_value(input logic [1:0] t);
    case (t)
      2'd0:    return 3'd2;
      2'd1:    return 3'd5;
      2'd2:    return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

  task automatic expectAward(input logic [1:0] t);
    exp_t e;
    exp_count = (exp_count == 63) ? 63 : exp_count + 1;
    e.val = item_value(t);
    e.cnt = 6'(exp_count);
    exp_q.push_back(e);
  endtask

  // A full catch. The grab is sampled at edge N and hook_home at edge N+d.
  // An optional second grab is driven at edge N+regrab_k and must be ignored.
  task automatic runCarry(input logic [1:0] t, input int d, input int period,
                          input int regrab_k, input logic [1:0] regrab_t);
    applyStimulus(1'b1, t, 1'b0, 1'b1);
    for (int k = 1; k <= d; k++) begin
      if (k == d) expectAward(t);
      applyStimulus(k == regrab_k, regrab_t, k == d, 1'b1);
      checkOutput("reel_step", reel_step, (k % period) == 0);
      checkOutput("carrying", carrying, 1);
      checkOutput("carried_type", carried_type, t);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("carrying_award_cycle", carrying, 1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("carrying_after_award", carrying, 0);
    checkOutput("reel_step_idle", reel_step, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (score_adder_enable) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_award", score_adder_enable, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("score_to_add", score_to_add, e.val);
        checkOutput("items_caught_at_award", items_caught, e.cnt);
      end
    end else begin
      checkOutput("score_to_add_idle", score_to_add, 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn      = 1'b0;
    game_active = 1'b0;
    grab_valid  = 1'b0;
    grab_type   = 2'd0;
    hook_home   = 1'b0;
    #23;
    checkOutput("reset_carrying", carrying, 0);
    checkOutput("reset_carried_type", carried_type, 0);
    checkOutput("reset_reel_step", reel_step, 0);
    checkOutput("reset_enable", score_adder_enable, 0);
    checkOutput("reset_items", items_caught, 0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);

    $display("[TB] test 1: diamond, light reel");
    runCarry(2'd3, 10, 4, 0, 2'd0);

    $display("[TB] test 2: big gold, heavy reel");
    runCarry(2'd1, 20, 8, 0, 2'd0);

    $display("[TB] test 3: stray home in IDLE, regrab in CARRY");
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("idle_home_carrying", carrying, 0);
    checkOutput("idle_home_items", items_caught, exp_count);
    runCarry(2'd0, 6, 4, 3, 2'd3);
    runCarry(2'd1, 5, 8, 5, 2'd2);

    $display("[TB] test 4: round ends mid-carry");
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("abort_carrying", carrying, 0);
    checkOutput("abort_items", items_caught, exp_count);
    checkOutput("abort_reel_step", reel_step, 0);

    $display("[TB] test 5: 65 rocks, counter saturates");
    for (int i = 0; i < 65; i++) begin
      runCarry(2'd2, 2, 8, 0, 2'd0);
    end
    checkOutput("items_saturated", items_caught, 63);

    $display("[TB] test 6: async reset during AWARD");
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    hook_home = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    exp_count = 0;
    checkOutput("async_carrying", carrying, 0);
    checkOutput("async_carried_type", carried_type, 0);
    checkOutput("async_enable", score_adder_enable, 0);
    checkOutput("async_score", score_to_add, 0);
    checkOutput("async_items", items_caught, 0);
    checkOutput("async_reel_step", reel_step, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("post_reset_carrying", carrying, 0);
    checkOutput("post_reset_items", items_caught, 0);
    runCarry(2'd3, 3, 4, 0, 2'd0);

    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("pending_awards", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
